button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner_pkg.sv | 34 +++
 rtl/button_conditioner_button_channel.sv | 133 +++++++++++++
 rtl/button_conditioner.sv | 111 +++++++++++
 tb/tb_button_conditioner.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared constants and types for the five-button conditioner: button indices,
// default timing, per-channel FSM states and the channel status payload.
package button_conditioner_pkg;

  localparam int unsigned NUM_BTN = 5;

  localparam int unsigned BTN_U = 0;
  localparam int unsigned BTN_D = 1;
  localparam int unsigned BTN_L = 2;
  localparam int unsigned BTN_R = 3;
  localparam int unsigned BTN_M = 4;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 250000;
  localparam int unsigned DEF_REPEAT_DELAY    = 50000000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 12500000;

  typedef enum logic [1:0] {
    CH_IDLE      = 2'd0,
    CH_HOLD_WAIT = 2'd1,
    CH_REPEAT    = 2'd2
  } chan_state_e;

  typedef struct packed {
    logic pressed;
    logic press_pulse;
    logic release_pulse;
    logic repeat_pulse;
  } chan_out_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_conditioner_button_channel.sv
// One button: 2-flop synchronizer, debounce counter, hold/repeat FSM and
// registered pulse outputs.
module button_channel
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  logic      repeat_en,
  output chan_out_t status,
  output logic      press_set_c
);

  localparam int unsigned DW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HOLD_MAX = max_u(REPEAT_DELAY, REPEAT_PERIOD);
  localparam int unsigned HW       = $clog2(HOLD_MAX + 1);

  logic          sync1;
  logic          sync2;
  logic [DW-1:0] deb_cnt;
  logic [DW-1:0] deb_cnt_d;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_cnt_d;
  chan_state_e   state;
  chan_state_e   state_d;
  logic          pressed_d;
  logic          press_d;
  logic          rel_d;
  logic          rpt_d;

  // Metastability guard for the raw asynchronous button
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= push;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= CH_IDLE;
      deb_cnt              <= '0;
      hold_cnt             <= '0;
      status.pressed       <= 1'b0;
      status.press_pulse   <= 1'b0;
      status.release_pulse <= 1'b0;
      status.repeat_pulse  <= 1'b0;
    end else begin
      state                <= state_d;
      deb_cnt              <= deb_cnt_d;
      hold_cnt             <= hold_cnt_d;
      status.pressed       <= pressed_d;
      status.press_pulse   <= press_d;
      status.release_pulse <= rel_d;
      status.repeat_pulse  <= rpt_d;
    end
  end

  always_comb begin
    deb_cnt_d   = deb_cnt;
    hold_cnt_d  = hold_cnt;
    state_d     = state;
    pressed_d   = status.pressed;
    press_d     = 1'b0;
    rel_d       = 1'b0;
    rpt_d       = 1'b0;
    press_set_c = 1'b0;

    // Debounce: a level change is accepted after DEBOUNCE_CYCLES differing samples
    if (sync2 == status.pressed) begin
      deb_cnt_d = '0;
    end else if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
      deb_cnt_d = '0;
      pressed_d = sync2;
      press_d   = sync2;
      rel_d     = ~sync2;
    end else begin
      deb_cnt_d = deb_cnt + DW'(1);
    end

    // Release takes priority over a repeat falling on the same edge
    unique case (state)
      CH_IDLE: begin
        hold_cnt_d = '0;
        if (press_d) begin
          state_d = CH_HOLD_WAIT;
        end
      end
      CH_HOLD_WAIT: begin
        if (rel_d) begin
          state_d    = CH_IDLE;
          hold_cnt_d = '0;
        end else if (!repeat_en) begin
          hold_cnt_d = '0;
        end else if (hold_cnt == HW'(REPEAT_DELAY - 1)) begin
          rpt_d      = 1'b1;
          hold_cnt_d = '0;
          state_d    = CH_REPEAT;
        end else begin
          hold_cnt_d = hold_cnt + HW'(1);
        end
      end
      CH_REPEAT: begin
        if (rel_d) begin
          state_d    = CH_IDLE;
          hold_cnt_d = '0;
        end else if (!repeat_en) begin
          hold_cnt_d = '0;
          state_d    = CH_HOLD_WAIT;
        end else if (hold_cnt == HW'(REPEAT_PERIOD - 1)) begin
          rpt_d      = 1'b1;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt + HW'(1);
        end
      end
      default: begin
        state_d    = CH_IDLE;
        hold_cnt_d = '0;
      end
    endcase

    press_set_c = press_d;
  end

endmodule

// File: rtl/button_conditioner.sv
// Five-button front panel conditioner: one button_channel per button plus a
// registered any_press aligned with the per-button press pulses.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] push,
  input  logic [NUM_BTN-1:0] repeat_en,
  output logic [NUM_BTN-1:0] pressed,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [NUM_BTN-1:0] release_pulse,
  output logic [NUM_BTN-1:0] repeat_pulse,
  output logic               any_press
);

  chan_out_t          ch_out [NUM_BTN];
  logic [NUM_BTN-1:0] press_set_c;

  button_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_btn_u (
    .clk        (clk),
    .reset      (reset),
    .push       (push[BTN_U]),
    .repeat_en  (repeat_en[BTN_U]),
    .status     (ch_out[BTN_U]),
    .press_set_c(press_set_c[BTN_U])
  );

  button_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_btn_d (
    .clk        (clk),
    .reset      (reset),
    .push       (push[BTN_D]),
    .repeat_en  (repeat_en[BTN_D]),
    .status     (ch_out[BTN_D]),
    .press_set_c(press_set_c[BTN_D])
  );

  button_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_btn_l (
    .clk        (clk),
    .reset      (reset),
    .push       (push[BTN_L]),
    .repeat_en  (repeat_en[BTN_L]),
    .status     (ch_out[BTN_L]),
    .press_set_c(press_set_c[BTN_L])
  );

  button_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_btn_r (
    .clk        (clk),
    .reset      (reset),
    .push       (push[BTN_R]),
    .repeat_en  (repeat_en[BTN_R]),
    .status     (ch_out[BTN_R]),
    .press_set_c(press_set_c[BTN_R])
  );

  button_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_btn_m (
    .clk        (clk),
    .reset      (reset),
    .push       (push[BTN_M]),
    .repeat_en  (repeat_en[BTN_M]),
    .status     (ch_out[BTN_M]),
    .press_set_c(press_set_c[BTN_M])
  );

  always_comb begin
    pressed       = '0;
    press_pulse   = '0;
    release_pulse = '0;
    repeat_pulse  = '0;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      pressed[i]       = ch_out[i].pressed;
      press_pulse[i]   = ch_out[i].press_pulse;
      release_pulse[i] = ch_out[i].release_pulse;
      repeat_pulse[i]  = ch_out[i].repeat_pulse;
    end
  end

  // Registered from the channels' next-press terms so it lines up with press_pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      any_press <= 1'b0;
    end else begin
      any_press <= |press_set_c;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with an edge-timestamp reference model.
module tb_button_conditioner;

  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;
  localparam int NB  = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] push;
  logic [NB-1:0] repeat_en;
  logic [NB-1:0] pressed;
  logic [NB-1:0] press_pulse;
  logic [NB-1:0] release_pulse;
  logic [NB-1:0] repeat_pulse;
  logic          any_press;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [NB-1:0]  m_pressed = '0;
  logic [NB-1:0]  m_press   = '0;
  logic [NB-1:0]  m_rel     = '0;
  logic [NB-1:0]  m_rpt     = '0;
  logic [NB-1:0]  m_p1      = '0;
  logic [NB-1:0]  m_p2      = '0;
  logic [DEB-1:0] m_win [NB];
  int             m_due [NB];
  int             m_edge = 0;

  int cyc;
  int cnt;
  int idx;
  int got [8];
  int exp_rpt [7] = '{10, 13, 16, 19, 22, 25, 28};

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .repeat_en    (repeat_en),
    .pressed      (pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .repeat_pulse (repeat_pulse),
    .any_press    (any_press)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // which: 0=press_pulse 1=release_pulse 2=repeat_pulse; cycles counted in negedges
  task automatic wait_bit(input int which, input int btn, input int limit, output int cycles);
    logic [NB-1:0] v;
    cycles = -1;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      case (which)
        0:       v = press_pulse;
        1:       v = release_pulse;
        default: v = repeat_pulse;
      endcase
      if (v[btn]) begin
        cycles = k;
        break;
      end
    end
    if (cycles < 0) begin
      total++;
      bad++;
      $display("FAIL timeout kind=%0d btn=%0d: got none want pulse within %0d", which, btn, limit);
    end
  endtask

  // Model: sync2 is the raw level two edges late; a level is accepted once the
  // last DEB samples all disagree with it; repeats are due at timestamps.
  initial begin
    for (int b = 0; b < NB; b++) begin
      m_win[b] = '0;
      m_due[b] = 0;
    end
    forever begin
      @(posedge clk);
      m_press = '0;
      m_rel   = '0;
      m_rpt   = '0;
      if (reset) begin
        m_p1      = '0;
        m_p2      = '0;
        m_pressed = '0;
        for (int b = 0; b < NB; b++) m_win[b] = '0;
      end else begin
        for (int b = 0; b < NB; b++) begin
          m_win[b] = {m_win[b][DEB-2:0], m_p2[b]};
          if (!m_pressed[b] && (&m_win[b])) begin
            m_pressed[b] = 1'b1;
            m_press[b]   = 1'b1;
            m_due[b]     = m_edge + RD;
          end else if (m_pressed[b] && !(|m_win[b])) begin
            m_pressed[b] = 1'b0;
            m_rel[b]     = 1'b1;
          end else if (m_pressed[b]) begin
            if (!repeat_en[b]) begin
              m_due[b] = m_edge + RD;
            end else if (m_edge == m_due[b]) begin
              m_rpt[b] = 1'b1;
              m_due[b] = m_edge + RP;
            end
          end
        end
        m_p2 = m_p1;
        m_p1 = push;
      end
      m_edge++;
    end
  end

  // Every-cycle comparison against the model
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("pressed", pressed, m_pressed);
      chk("press_pulse", press_pulse, m_press);
      chk("release_pulse", release_pulse, m_rel);
      chk("repeat_pulse", repeat_pulse, m_rpt);
      chk("any_press", {4'b0, any_press}, {4'b0, |m_press});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish before 100000");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    push      = '0;
    repeat_en = '0;
    repeat (3) @(negedge clk);
    chk("rst_pressed", pressed, 5'b0);
    chk("rst_pulses", press_pulse | release_pulse | repeat_pulse, 5'b0);
    chk("rst_any", {4'b0, any_press}, 5'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Clean press on button 0
    push[0] = 1'b1;
    wait_bit(0, 0, 20, cyc);
    chk_int("press_latency", cyc - 1, 5);
    chk("press_vec", press_pulse, 5'b00001);
    chk("any_on_press", {4'b0, any_press}, 5'b00001);
    chk("pressed_after", pressed, 5'b00001);
    @(negedge clk);
    chk("press_one_cycle", press_pulse, 5'b0);
    push[0] = 1'b0;
    repeat (12) @(negedge clk);

    // Bounce on button 4 with runs of 3
    cnt     = 0;
    push[4] = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (press_pulse[4] || release_pulse[4]) cnt++;
      if (i % 3 == 2) push[4] = ~push[4];
    end
    push[4] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (press_pulse[4] || release_pulse[4]) cnt++;
    end
    chk_int("bounce_pulses", cnt, 0);
    chk_int("bounce_pressed", int'(pressed[4]), 0);

    // Auto-repeat on button 2
    repeat_en[2] = 1'b1;
    push[2]      = 1'b1;
    wait_bit(0, 2, 20, cyc);
    idx = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (repeat_pulse[2]) begin
        if (idx < 8) got[idx] = k;
        idx++;
      end
    end
    chk_int("rpt_count", idx, 7);
    for (int i = 0; i < 7; i++) chk_int("rpt_offset", (i < idx) ? got[i] : -1, exp_rpt[i]);
    push[2] = 1'b0;
    repeat (12) @(negedge clk);

    // Repeat disabled, then re-enabled mid-hold
    repeat_en[2] = 1'b0;
    push[2]      = 1'b1;
    wait_bit(0, 2, 20, cyc);
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (repeat_pulse[2]) cnt++;
    end
    chk_int("rpt_disabled", cnt, 0);
    repeat_en[2] = 1'b1;
    wait_bit(2, 2, 20, cyc);
    chk_int("rpt_reenable", cyc, 10);
    push[2] = 1'b0;
    repeat (12) @(negedge clk);

    // Release on button 1, timed to coincide with the first repeat
    repeat_en[1] = 1'b1;
    push[1]      = 1'b1;
    wait_bit(0, 1, 20, cyc);
    repeat (4) @(negedge clk);
    push[1] = 1'b0;
    wait_bit(1, 1, 20, cyc);
    chk_int("release_latency", cyc - 1, 5);
    chk("no_rpt_on_release", repeat_pulse, 5'b0);
    chk("pressed_after_rel", pressed, 5'b0);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (repeat_pulse[1]) cnt++;
    end
    chk_int("rpt_after_release", cnt, 0);

    // Simultaneous press of buttons 0 and 3, then reset mid-hold
    push[0] = 1'b1;
    push[3] = 1'b1;
    wait_bit(0, 0, 20, cyc);
    chk("simul_press", press_pulse, 5'b01001);
    chk("simul_any", {4'b0, any_press}, 5'b00001);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_hold_pressed", pressed, 5'b0);
    chk("rst_hold_release", release_pulse, 5'b0);
    chk("rst_hold_pulses", press_pulse | repeat_pulse, 5'b0);
    chk("rst_hold_any", {4'b0, any_press}, 5'b0);
    @(negedge clk);
    reset = 1'b0;
    wait_bit(0, 3, 20, cyc);
    chk_int("fresh_press_latency", cyc - 1, 5);
    chk("fresh_press_vec", press_pulse, 5'b01001);
    push = '0;
    repeat (12) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
